// File: rtl/mem_stage_ctrl.sv
// Memory stage between execute and writeback: one op in flight, req/ack data-memory port.
// Optional MEM_MISALIGN_CHECK_EN rejects memory ops whose address is not size-aligned.
//
// state | meaning
// IDLE  | ready for a new op; non-memory and rejected ops complete from here
// REQ   | dm_req held until dm_ack or wait-counter terminal count
module mem_stage_ctrl #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_write,
  input  logic              read_enable,
  input  logic              mem_to_reg,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_xfer_size,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_nxt;
  logic              dm_req_nxt, dm_we_nxt;
  logic [ADDR_W-1:0] dm_addr_nxt;
  logic [DATA_W-1:0] dm_wdata_nxt;
  logic [3:0]        dm_xfer_size_nxt;
  logic              out_valid_nxt, out_err_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [CNT_W-1:0]  stall_cycles_nxt;
  logic [1:0]        size_q, size_q_nxt;
  logic              sign_ext_q, sign_ext_q_nxt;
  logic              mem_to_reg_q, mem_to_reg_q_nxt;
  logic [31:0]       wait_cnt, wait_cnt_nxt;
  logic              mem_op, illegal, reject;

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] sz, input logic sx);
    logic [DATA_W-1:0] res;
    int                nbits;
    logic              msb;
    nbits = 8 << sz;
    if (nbits > DATA_W) nbits = DATA_W;
    msb = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == nbits - 1) msb = raw[i];
    for (int i = 0; i < DATA_W; i++)
      res[i] = (i < nbits) ? raw[i] : (sx & msb);
    return res;
  endfunction

  assign in_ready = (state == IDLE);
  assign mem_op   = mem_write | read_enable;
  assign illegal  = (DATA_W == 32) && (size == 2'b11);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00: misalign = 1'b0;
      2'b01: misalign = address[0];
      2'b10: misalign = |address[1:0];
      2'b11: misalign = |address[2:0];
      default: misalign = 1'b0;
    endcase
  end
  assign reject = illegal | misalign;
`else
  assign reject = illegal;
`endif

  always_comb begin
    state_nxt        = state;
    dm_req_nxt       = dm_req;
    dm_we_nxt        = dm_we;
    dm_addr_nxt      = dm_addr;
    dm_wdata_nxt     = dm_wdata;
    dm_xfer_size_nxt = dm_xfer_size;
    out_valid_nxt    = 1'b0;
    out_err_nxt      = 1'b0;
    out_data_nxt     = out_data;
    size_q_nxt       = size_q;
    sign_ext_q_nxt   = sign_ext_q;
    mem_to_reg_q_nxt = mem_to_reg_q;
    wait_cnt_nxt     = wait_cnt;
    stall_cycles_nxt = stall_cycles;

    if (!in_ready && (stall_cycles != '1))
      stall_cycles_nxt = stall_cycles + CNT_W'(1);

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = DATA_W'(address);
          end else if (reject) begin
            out_valid_nxt = 1'b1;
            out_err_nxt   = 1'b1;
            out_data_nxt  = DATA_W'(address);
          end else begin
            // a write with read_enable also set is treated purely as a store
            state_nxt        = REQ;
            dm_req_nxt       = 1'b1;
            dm_we_nxt        = mem_write;
            dm_addr_nxt      = address;
            dm_wdata_nxt     = write_data;
            dm_xfer_size_nxt = 4'b0001 << size;
            size_q_nxt       = size;
            sign_ext_q_nxt   = sign_ext;
            mem_to_reg_q_nxt = mem_to_reg;
            wait_cnt_nxt     = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : '0;
          end
        end
      end
      REQ: begin
        if (dm_ack) begin
          state_nxt     = IDLE;
          dm_req_nxt    = 1'b0;
          out_valid_nxt = 1'b1;
          out_data_nxt  = (!dm_we && mem_to_reg_q) ? load_extend(dm_rdata, size_q, sign_ext_q)
                                                   : DATA_W'(dm_addr);
        end else if ((TIMEOUT > 0) && (wait_cnt == '0)) begin
          state_nxt     = IDLE;
          dm_req_nxt    = 1'b0;
          out_valid_nxt = 1'b1;
          out_err_nxt   = 1'b1;
          out_data_nxt  = DATA_W'(dm_addr);
        end else if (TIMEOUT > 0) begin
          wait_cnt_nxt = wait_cnt - 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_xfer_size <= '0;
      out_valid    <= 1'b0;
      out_err      <= 1'b0;
      out_data     <= '0;
      size_q       <= '0;
      sign_ext_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      dm_req       <= dm_req_nxt;
      dm_we        <= dm_we_nxt;
      dm_addr      <= dm_addr_nxt;
      dm_wdata     <= dm_wdata_nxt;
      dm_xfer_size <= dm_xfer_size_nxt;
      out_valid    <= out_valid_nxt;
      out_err      <= out_err_nxt;
      out_data     <= out_data_nxt;
      size_q       <= size_q_nxt;
      sign_ext_q   <= sign_ext_q_nxt;
      mem_to_reg_q <= mem_to_reg_q_nxt;
      wait_cnt     <= wait_cnt_nxt;
      stall_cycles <= stall_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl (DATA_W=64, TIMEOUT=5, CNT_W=4 so stall_cycles saturates).
module tb_mem_stage_ctrl;
  localparam int DW = 64, AW = 64, TO = 5, CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic          mem_write = 1'b0, read_enable = 1'b0, mem_to_reg = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sign_ext = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] write_data = '0;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_xfer_size;
  logic          dm_ack = 1'b0;
  logic [DW-1:0] dm_rdata = '0;
  logic          out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cycles;

  int errors = 0, checks = 0;
  int exp_stall = 0;
  logic [DW-1:0] q_data[$];
  logic          q_err[$];

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mem_write(mem_write), .read_enable(read_enable), .mem_to_reg(mem_to_reg),
    .size(size), .sign_ext(sign_ext), .address(address), .write_data(write_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_xfer_size(dm_xfer_size), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every result pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_data %h with no result expected", out_data);
      end else begin
        logic [DW-1:0] ed;
        logic          ee;
        ed = q_data.pop_front();
        ee = q_err.pop_front();
        chk("sb_out_data", out_data, ed);
        chk("sb_out_err", {63'd0, out_err}, {63'd0, ee});
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic m2r, input logic [1:0] sz,
                       input logic sx, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    in_valid = 1'b1; mem_write = we; read_enable = re; mem_to_reg = m2r;
    size = sz; sign_ext = sx; address = addr; write_data = wd;
    tick();
    in_valid = 1'b0; mem_write = 1'b0; read_enable = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // ack_delay < 0 means never acknowledge (timeout expected)
  task automatic do_mem(input string name, input logic we, input logic re, input logic m2r,
                        input logic [1:0] sz, input logic sx, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int ack_delay,
                        input logic [DW-1:0] exp_data, input logic exp_err);
    int n, exp_n;
    logic [3:0] exp_xfer;
    exp_xfer = 4'b0001 << sz;
    exp_n = (ack_delay < 0) ? TO : ack_delay + 1;
    drive(we, re, m2r, sz, sx, addr, wd);
    q_data.push_back(exp_data);
    q_err.push_back(exp_err);
    n = 0;
    while (dm_req === 1'b1 && n < 20) begin
      chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({name, "_dm_addr"}, dm_addr, addr);
      chk({name, "_dm_we"}, {63'd0, dm_we}, {63'd0, we});
      chk({name, "_xfer"}, {60'd0, dm_xfer_size}, {60'd0, exp_xfer});
      if (we) chk({name, "_dm_wdata"}, dm_wdata, wd);
      if (n == ack_delay) begin
        dm_ack = 1'b1;
        dm_rdata = rd;
      end
      tick();
      n++;
    end
    dm_ack = 1'b0;
    dm_rdata = '0;
    chk({name, "_req_cycles"}, 64'(n), 64'(exp_n));
    chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
    exp_stall = sat(exp_stall + exp_n);
    chk({name, "_stall"}, {60'd0, stall_cycles}, 64'(exp_stall));
    tick();
    chk({name, "_pulse_end"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_dm_req", {63'd0, dm_req}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall", {60'd0, stall_cycles}, 64'd0);
    reset = 1'b0;
    tick();

    // load byte, sign-extended, ack 3 cycles after dm_req
    do_mem("lb", 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 64'h10, 64'h0,
           64'h1234_5678_9ABC_DE80, 3, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    // store double, ack with the first dm_req; read_enable also set is ignored
    do_mem("sd", 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 64'h20, 64'hDEAD_BEEF_0123_4567,
           64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h20, 1'b0);
    // load half zero-extended
    do_mem("lhu", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 64'h40, 64'h0,
           64'hFFFF_FFFF_FFFF_8001, 1, 64'h0000_0000_0000_8001, 1'b0);
    // load word sign-extended
    do_mem("lw", 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 64'h44, 64'h0,
           64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    // load double, mem_to_reg=0 writes back the address
    do_mem("ld_addr", 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 64'h88, 64'h0,
           64'h5555_5555_5555_5555, 2, 64'h88, 1'b0);

    // non-memory op
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 64'h1234, 64'h0);
    q_data.push_back(64'h1234);
    q_err.push_back(1'b0);
    chk("alu_out_valid", {63'd0, out_valid}, 64'd1);
    chk("alu_dm_req", {63'd0, dm_req}, 64'd0);
    chk("alu_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("alu_dm_req_after", {63'd0, dm_req}, 64'd0);

    // timeout: no ack at all, then ack exactly on the timeout cycle
    do_mem("timeout", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 64'h100, 64'h0, 64'h0, -1, 64'h100, 1'b1);
    do_mem("ack_at_to", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 64'h104, 64'h0,
           64'h0000_0000_0000_00C3, 4, 64'hC3, 1'b0);
    chk("stall_saturated", {60'd0, stall_cycles}, 64'd15);

`ifdef MEM_MISALIGN_CHECK_EN
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 64'h3, 64'h0);
    q_data.push_back(64'h3);
    q_err.push_back(1'b1);
    chk("mis_dm_req", {63'd0, dm_req}, 64'd0);
    chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
    chk("mis_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
`else
    do_mem("mis", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 64'h3, 64'h0,
           64'h0000_0000_0000_00AB, 0, 64'hAB, 1'b0);
`endif

    // reset in the middle of a request, then a late ack
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 64'h50, 64'h77);
    chk("rstreq_dm_req", {63'd0, dm_req}, 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_stall = 0;
    chk("rstreq_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rstreq_dm_req_low", {63'd0, dm_req}, 64'd0);
    chk("rstreq_dm_we", {63'd0, dm_we}, 64'd0);
    chk("rstreq_dm_addr", dm_addr, 64'd0);
    chk("rstreq_dm_wdata", dm_wdata, 64'd0);
    chk("rstreq_xfer", {60'd0, dm_xfer_size}, 64'd0);
    chk("rstreq_out_data", out_data, 64'd0);
    chk("rstreq_out_err", {63'd0, out_err}, 64'd0);
    chk("rstreq_stall", {60'd0, stall_cycles}, 64'd0);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("late_ack_out_valid", {63'd0, out_valid}, 64'd0);
    chk("late_ack_dm_req", {63'd0, dm_req}, 64'd0);
    chk("late_ack_stall", {60'd0, stall_cycles}, 64'(exp_stall));
    tick();
    tick();
    chk("sb_empty", 64'(q_data.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised memory stage for the in-order pipeline, between execute and writeback.
- Accepts one op at a time and drives a request/acknowledge data-memory port with variable latency.
- Supports byte, half, word and double access sizes, with sign or zero extension on loads.
- Selects memory data or the address/ALU result for writeback; stalls upstream while an access is outstanding, with an optional timeout abort.

Parameters:
- DATA_W, 64, datapath width; legal values 32 or 64.
- ADDR_W, 64, address width.
- TIMEOUT, 0, max wait cycles for dm_ack; 0 = wait forever.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  op presented this cycle.
- in_ready  out  1  stage can accept an op.
- mem_write  in  1  store op.
- read_enable  in  1  load op.
- mem_to_reg  in  1  1 = writeback loaded data; 0 = writeback address.
- size  in  2  00 byte, 01 half, 10 word, 11 double.
- sign_ext  in  1  sign-extend loads.
- address  in  ADDR_W  effective address / ALU result.
- write_data  in  DATA_W  store data, low bytes significant.
- dm_req  out  1  memory request.
- dm_we  out  1  request is a write.
- dm_addr  out  ADDR_W  request address.
- dm_wdata  out  DATA_W  request write data.
- dm_xfer_size  out  4  0001, 0010, 0100 or 1000 bytes.
- dm_ack  in  1  memory completes request this cycle.
- dm_rdata  in  DATA_W  read data, addressed bytes in low bits.
- out_valid  out  1  one-cycle result pulse.
- out_data  out  DATA_W  writeback value.
- out_err  out  1  qualifies out_valid: op aborted or illegal.
- stall_cycles  out  CNT_W  saturating count of cycles with in_ready=0.

Behaviour:
- Reset values: state IDLE; in_ready=1; dm_req=0; dm_we=0; dm_addr=0; dm_wdata=0; dm_xfer_size=0; out_valid=0; out_data=0; out_err=0; stall_cycles=0.
- States: IDLE, REQ.
- IDLE: in_ready=1. An op is accepted on in_valid.
- Accept, no memory op (read_enable=0, mem_write=0): next cycle out_valid=1, out_data=address truncated/zero-padded to DATA_W, out_err=0. Stay IDLE.
- Accept, memory op: latch all inputs, go to REQ. dm_req=1 from the next cycle.
- If mem_write=1 and read_enable=1 together, the op is a store; the read is ignored.
- REQ: in_ready=0. dm_req, dm_we, dm_addr, dm_wdata and dm_xfer_size are held stable until the cycle dm_ack=1, inclusive.
- Cycle after dm_ack: dm_req=0, out_valid=1, out_err=0, return to IDLE.
  - Load with mem_to_reg=1: out_data = dm_rdata low 8/16/32/64 bits, sign- or zero-extended to DATA_W.
  - Load with mem_to_reg=0, or any store: out_data = address.
- dm_ack while dm_req=0 is ignored.
- Minimum memory-op latency: accept at cycle T, dm_req at T+1, ack at T+1, out_valid at T+2.
- Timeout (TIMEOUT>0): a wait counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT: drop dm_req, out_valid=1, out_err=1, out_data=address, return to IDLE. An ack in the same cycle as the timeout wins (normal completion).
- DATA_W=32 with size=11: no request; next cycle out_valid=1, out_err=1, out_data=address.
- stall_cycles increments every cycle in_ready=0 and saturates at all-ones.
- Reset mid-REQ: next edge forces IDLE with all reset values; a late dm_ack is ignored.
- out_valid is a single-cycle pulse; there is no downstream backpressure.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: a memory op whose address is not a multiple of its access size issues no request. Next cycle: out_valid=1, out_err=1, out_data=address; stage stays IDLE.
- Undefined: no alignment check; the request is issued with the address unchanged.

Test Plan:
- Load byte, address=0x10, size=00, sign_ext=1, mem_to_reg=1, dm_rdata=0x..80, ack 3 cycles after dm_req -> out_data=0xFFFFFFFFFFFFFF80; in_ready=0 for 4 cycles; stall_cycles=4.
- Store double, address=0x20, write_data=0xDEADBEEF01234567, ack in same cycle as first dm_req -> dm_we=1, dm_xfer_size=1000, dm_wdata matches; out_valid 2 cycles after accept with out_data=0x20.
- Non-memory op, address=0x1234 -> out_valid next cycle, out_data=0x1234, dm_req never asserted.
- TIMEOUT=5, no ack -> dm_req high exactly 5 cycles, then out_valid=1 and out_err=1; the following op is accepted.
- Reset asserted during REQ, then a late dm_ack -> all outputs at reset values, no out_valid pulse.
- With MEM_MISALIGN_CHECK_EN defined: half load at address=0x3 -> out_err=1, no dm_req. With the macro undefined: request issued with dm_addr=0x3.
